// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: two-stage valid/ready unsigned multiplier with a per-beat exact/approximate mode.
// Define APPROX_MULT_COMP_EN to add a 2^(WIDTH-2) bias term to approximate-mode results.
module approx_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_ROWS = 6,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_z,
  output logic               out_mode,
  output logic [CNT_W-1:0]   approx_cnt
);

  localparam int PW = 2 * WIDTH;
  // Bits of weight below WIDTH-1 in the approximated rows are discarded.
  localparam logic [PW-1:0] KEEP_MASK = ~((PW'(1) << (WIDTH - 1)) - PW'(1));
`ifdef APPROX_MULT_COMP_EN
  localparam logic [PW-1:0] COMP_TERM = PW'(1) << (WIDTH - 2);
`endif

  logic [PW-1:0] row_exact [WIDTH];
  logic [PW-1:0] pp_next   [WIDTH];
  logic [PW-1:0] s1_pp     [WIDTH];
  logic          s1_valid;
  logic          s1_mode;
  logic          s2_load;
  logic          s1_adv;
  logic          accept;
  logic [PW-1:0] sum;

  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    assign row_exact[i] = {{WIDTH{1'b0}}, in_y & {WIDTH{in_x[i]}}} << i;
  end

  // In approximate mode each row pair collapses into slot 2k; already aligned rows OR per weight.
  for (genvar k = 0; k < WIDTH; k++) begin : g_slot
    if (k >= APPROX_ROWS) begin : g_exact
      assign pp_next[k] = row_exact[k];
    end else if (k % 2 == 0) begin : g_pair
      assign pp_next[k] = in_mode ? ((row_exact[k] | row_exact[k+1]) & KEEP_MASK)
                                  : row_exact[k];
    end else begin : g_odd
      assign pp_next[k] = in_mode ? '0 : row_exact[k];
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < WIDTH; k++) begin
      sum = sum + s1_pp[k];
    end
`ifdef APPROX_MULT_COMP_EN
    if (s1_mode) begin
      sum = sum + COMP_TERM;
    end
`endif
  end

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = s2_load;
  assign in_ready = !s1_valid || s1_adv;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_mode    <= 1'b0;
      out_valid  <= 1'b0;
      out_z      <= '0;
      out_mode   <= 1'b0;
      approx_cnt <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (accept) begin
        s1_pp   <= pp_next;
        s1_mode <= in_mode;
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_z    <= sum;
          out_mode <= s1_mode;
        end
      end
      if (out_valid && out_ready && out_mode && (approx_cnt != '1)) begin
        approx_cnt <= approx_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe: behavioural multiplier model plus in-order scoreboard.
module tb_approx_mult_pipe;

  localparam int W   = 8;
  localparam int AR  = 6;
  localparam int CW  = 4;
  localparam int PW  = 2 * W;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_x = '0;
  logic [W-1:0]  in_y = '0;
  logic          in_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] out_z;
  logic          out_mode;
  logic [CW-1:0] approx_cnt;

  int checks = 0;
  int passes = 0;

  logic [PW-1:0] exp_z [$];
  logic          exp_mode [$];
  int            model_cnt = 0;
  logic          stalled = 1'b0;
  logic [PW-1:0] held_z;
  logic          held_mode;
  int            n_before;
  logic [PW-1:0] pz;
  logic          pm;
  logic          acc;

  approx_mult_pipe #(.WIDTH(W), .APPROX_ROWS(AR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_mode(out_mode),
    .approx_cnt(approx_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference product built weight by weight from the row/pair rules.
  function automatic longint model_mult(input logic [W-1:0] x, input logic [W-1:0] y, input logic mode);
    longint total = 0;
    for (int i = 0; i < W; i++) begin
      if (!mode || i >= AR) begin
        for (int j = 0; j < W; j++)
          if (x[i] && y[j]) total += longint'(1) << (i + j);
      end else if (i % 2 == 0) begin
        for (int w = W - 1; w < 2 * W; w++) begin
          logic a, b;
          a = 1'b0;
          b = 1'b0;
          if (w - i >= 0 && w - i < W) a = x[i] & y[w-i];
          if (w - i - 1 >= 0 && w - i - 1 < W) b = x[i+1] & y[w-i-1];
          if (a || b) total += longint'(1) << w;
        end
      end
    end
`ifdef APPROX_MULT_COMP_EN
    if (mode) total += longint'(1) << (W - 2);
`endif
    return total % (longint'(1) << (2 * W));
  endfunction

  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic mode);
    logic got;
    int waited;
    got = 1'b0;
    waited = 0;
    in_x = x;
    in_y = y;
    in_mode = mode;
    in_valid = 1'b1;
    while (!got && waited < 50) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!got) checkOutput("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Compare process: scoreboard, counter model, ready model and stall hold check each cycle.
  always @(negedge clk) begin
    checkOutput("approx_cnt", approx_cnt, model_cnt);
    if (stalled) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_z", out_z, held_z);
      checkOutput("hold_mode", out_mode, held_mode);
    end
    if (rst) begin
      exp_z.delete();
      exp_mode.delete();
      model_cnt = 0;
      stalled = 1'b0;
    end else begin
      n_before = exp_z.size();
      checkOutput("in_ready", in_ready, (n_before < 2) || out_ready);
      if (out_valid && out_ready) begin
        if (exp_z.size() == 0) begin
          checkOutput("retire_unexpected", 1, 0);
        end else begin
          pz = exp_z.pop_front();
          pm = exp_mode.pop_front();
          checkOutput("retire_z", out_z, pz);
          checkOutput("retire_mode", out_mode, pm);
          if (pm && model_cnt < CNT_MAX) model_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        exp_z.push_back(PW'(model_mult(in_x, in_y, in_mode)));
        exp_mode.push_back(in_mode);
      end
      stalled = out_valid && !out_ready;
      held_z = out_z;
      held_mode = out_mode;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_z", out_z, 0);
    checkOutput("reset_out_mode", out_mode, 0);
    checkOutput("reset_approx_cnt", approx_cnt, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    checkOutput("model_exact_255", model_mult(8'd255, 8'd255, 1'b0), 65025);
    checkOutput("model_exact_3_c0", model_mult(8'd3, 8'hC0, 1'b0), 576);
`ifdef APPROX_MULT_COMP_EN
    checkOutput("model_approx_3_c0", model_mult(8'd3, 8'hC0, 1'b1), 448);
    checkOutput("model_approx_40_200", model_mult(8'h40, 8'd200, 1'b1), 12864);
    checkOutput("model_approx_1_7f", model_mult(8'd1, 8'h7F, 1'b1), 64);
`else
    checkOutput("model_approx_3_c0", model_mult(8'd3, 8'hC0, 1'b1), 384);
    checkOutput("model_approx_40_200", model_mult(8'h40, 8'd200, 1'b1), 12800);
    checkOutput("model_approx_1_7f", model_mult(8'd1, 8'h7F, 1'b1), 0);
`endif

    out_ready = 1'b1;
    applyStimulus(8'd255, 8'd255, 1'b0);
    @(negedge clk);
    checkOutput("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    checkOutput("lat_cycle2_valid", out_valid, 1);
    checkOutput("lat_z", out_z, 65025);
    checkOutput("lat_mode", out_mode, 0);
    @(posedge clk);
    #1;
    checkOutput("cnt_after_exact", approx_cnt, 0);

    applyStimulus(8'h40, 8'd200, 1'b1);
    applyStimulus(8'd1, 8'h7F, 1'b1);
    applyStimulus(8'd3, 8'hC0, 1'b1);
    applyStimulus(8'd3, 8'hC0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("cnt_after_directed", approx_cnt, 3);

    repeat (20) applyStimulus(W'($urandom), W'($urandom), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("cnt_saturated", approx_cnt, CNT_MAX);

    // Backpressure: two beats fill both stages, a third waits.
    out_ready = 1'b0;
    applyStimulus(8'd11, 8'd22, 1'b0);
    applyStimulus(8'hAB, 8'hCD, 1'b1);
    in_x = 8'h5A;
    in_y = 8'h77;
    in_mode = 1'b1;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_stream_valid", out_valid, 1);
      @(posedge clk);
      #1;
      if (i == 0) in_valid = 1'b0;
    end

    // Reset with two beats in flight; in_valid held high during reset.
    out_ready = 1'b0;
    applyStimulus(8'd200, 8'd100, 1'b1);
    applyStimulus(8'd17, 8'd33, 1'b1);
    rst = 1'b1;
    in_x = 8'd9;
    in_y = 8'd9;
    in_mode = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_approx_cnt", approx_cnt, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    applyStimulus(8'h40, 8'd200, 1'b1);
    @(negedge clk);
    checkOutput("post_rst_cycle1_valid", out_valid, 0);
    @(negedge clk);
    checkOutput("post_rst_cycle2_valid", out_valid, 1);
    checkOutput("post_rst_z", out_z, model_mult(8'h40, 8'd200, 1'b1));
    @(posedge clk);
    #1;

    acc = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_x = W'($urandom);
        in_y = W'($urandom);
        if ($urandom_range(0, 7) == 0) in_x = 8'hFF;
        if ($urandom_range(0, 7) == 0) in_y = 8'hFF;
        in_mode = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_z.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("drain_empty", exp_z.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
